// File: rtl/counter_monitor.sv
// In-system observer for an up/down counter bus: infers direction, flags illegal steps, counts errors.
// Optional sticky error flag with clear input when CNT_MON_STICKY_ERR_EN is defined.
module counter_monitor #(
  parameter int W         = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [W-1:0]         din,
  input  logic                 up_exp,
`ifdef CNT_MON_STICKY_ERR_EN
  input  logic                 err_clr,
  output logic                 err_sticky,
`endif
  output logic                 locked,
  output logic                 dir_up,
  output logic                 wrap,
  output logic                 resync,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  // Sample interface: din/up_exp are consumed on a rising edge only when en=1;
  // there is no back-pressure, every enabled sample is taken.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [W-1:0]         VAL_MAX = '1;
  localparam logic [W-1:0]         VAL_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [W-1:0]           prev_q, prev_d;
  logic                   dir_q, dir_d;
  logic                   wrap_q, wrap_d;
  logic                   resync_q, resync_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

  logic [W-1:0] prev_inc;
  logic [W-1:0] prev_dec;
  logic         step_up;
  logic         step_dn;
  logic         wrap_up;
  logic         wrap_dn;
  logic         din_zero;

  assign prev_inc = prev_q + VAL_ONE;
  assign prev_dec = prev_q - VAL_ONE;
  assign step_up  = (din == prev_inc);
  assign step_dn  = (din == prev_dec);
  assign wrap_up  = step_up && (prev_q == VAL_MAX);
  assign wrap_dn  = step_dn && (prev_q == '0);
  assign din_zero = (din == '0);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    resync_d = 1'b0;
    err_d    = 1'b0;
    if (en) begin
      prev_d = din;
      case (state_q)
        S_IDLE: state_d = S_ACQ;
        S_ACQ: begin
          // First step after acquisition sets direction without consulting up_exp.
          if (step_up) begin
            dir_d   = 1'b1;
            wrap_d  = wrap_up;
            state_d = S_TRACK;
          end else if (step_dn) begin
            dir_d   = 1'b0;
            wrap_d  = wrap_dn;
            state_d = S_TRACK;
          end else if (din_zero) begin
            resync_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_FAULT;
          end
        end
        S_TRACK: begin
          if (up_exp ? step_up : step_dn) begin
            dir_d  = up_exp;
            wrap_d = up_exp ? wrap_up : wrap_dn;
          end else if (step_up || step_dn) begin
            err_d   = 1'b1;
            dir_d   = step_up;
            state_d = S_FAULT;
          end else if (din_zero) begin
            resync_d = 1'b1;
            state_d  = S_ACQ;
          end else begin
            err_d   = 1'b1;
            state_d = S_FAULT;
          end
        end
        S_FAULT: state_d = S_ACQ;
        default: state_d = S_IDLE;
      endcase
    end
    cnt_d = (err_d && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      dir_q    <= 1'b0;
      wrap_q   <= 1'b0;
      resync_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      dir_q    <= dir_d;
      wrap_q   <= wrap_d;
      resync_q <= resync_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef CNT_MON_STICKY_ERR_EN
  logic sticky_q;

  // A new error outranks a clear arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (err_d) begin
      sticky_q <= 1'b1;
    end else if (err_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign err_sticky = sticky_q;
`endif

  assign locked    = (state_q == S_TRACK);
  assign dir_up    = dir_q;
  assign wrap      = wrap_q;
  assign resync    = resync_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: directed scenarios plus random samples against a sample-level reference model.
module tb_counter_monitor;

  localparam int W         = 4;
  localparam int ERR_CNT_W = 8;
  localparam int MASK      = (1 << W) - 1;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
  localparam int OUT_W     = 5 + ERR_CNT_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 en;
  logic [W-1:0]         din;
  logic                 up_exp;
  logic                 locked;
  logic                 dir_up;
  logic                 wrap;
  logic                 resync;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [1:0]           dbg_state;
`ifdef CNT_MON_STICKY_ERR_EN
  logic                 err_clr;
  logic                 err_sticky;
`endif

  counter_monitor #(.W(W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .up_exp    (up_exp),
`ifdef CNT_MON_STICKY_ERR_EN
    .err_clr   (err_clr),
    .err_sticky(err_sticky),
`endif
    .locked    (locked),
    .dir_up    (dir_up),
    .wrap      (wrap),
    .resync    (resync),
    .err       (err),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s got=%0h exp=%0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // reference model: tracks what the spec says per enabled sample
  typedef enum int {M_IDLE, M_ACQ, M_TRACK, M_FAULT} mode_e;
  mode_e m_mode;
  int    m_prev;
  bit    m_dir;
  int    m_cnt;
  bit    m_sticky;
  bit    e_wrap, e_resync, e_err;
  int    wrap_seen;
  logic [OUT_W-1:0] exp_q[$];

  function automatic void model_reset();
    m_mode = M_IDLE; m_prev = 0; m_dir = 0; m_cnt = 0; m_sticky = 0;
    e_wrap = 0; e_resync = 0; e_err = 0;
  endfunction

  function automatic void model_sample(bit e, int d, bit u, bit clr);
    int  delta;
    bit  up1, dn1, crosses;
    e_wrap = 0; e_resync = 0; e_err = 0;
    if (e) begin
      delta   = (d - m_prev) & MASK;
      up1     = (delta == 1);
      dn1     = (delta == MASK);
      crosses = (up1 && d == 0) || (dn1 && d == MASK);
      case (m_mode)
        M_IDLE:  m_mode = M_ACQ;
        M_ACQ: begin
          if (up1 || dn1) begin
            m_dir = up1; e_wrap = crosses; m_mode = M_TRACK;
          end else if (d == 0) e_resync = 1;
          else begin e_err = 1; m_mode = M_FAULT; end
        end
        M_TRACK: begin
          if ((u && up1) || (!u && dn1)) begin
            m_dir = u; e_wrap = crosses;
          end else if (up1 || dn1) begin
            e_err = 1; m_dir = up1; m_mode = M_FAULT;
          end else if (d == 0) begin
            e_resync = 1; m_mode = M_ACQ;
          end else begin
            e_err = 1; m_mode = M_FAULT;
          end
        end
        default: m_mode = M_ACQ;
      endcase
      m_prev = d;
    end
    if (e_err && m_cnt < CNT_MAX) m_cnt++;
    if (e_err) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endfunction

  // driver: apply at negedge, check 1 time unit after the sampling edge
  task automatic cycle(input bit e, input int d, input bit u, input bit clr = 0);
    logic [OUT_W-1:0] x;
    @(negedge clk);
    en = e; din = d[W-1:0]; up_exp = u;
`ifdef CNT_MON_STICKY_ERR_EN
    err_clr = clr;
`endif
    @(posedge clk); #1;
    model_sample(e, d, u, clr);
    if (e_wrap) wrap_seen++;
    exp_q.push_back({(m_mode == M_TRACK), m_dir, e_wrap, e_resync, e_err, m_cnt[ERR_CNT_W-1:0]});
    x = exp_q.pop_front();
    chk("locked",  locked,  x[OUT_W-1]);
    chk("dir_up",  dir_up,  x[OUT_W-2]);
    chk("wrap",    wrap,    x[OUT_W-3]);
    chk("resync",  resync,  x[OUT_W-4]);
    chk("err",     err,     x[OUT_W-5]);
    chk("err_cnt", err_cnt, x[ERR_CNT_W-1:0]);
`ifdef CNT_MON_STICKY_ERR_EN
    chk("sticky",  err_sticky, m_sticky);
`endif
  endtask

  task automatic chk_all_zero();
    chk("rst_locked", locked, 0);
    chk("rst_dir",    dir_up, 0);
    chk("rst_wrap",   wrap,   0);
    chk("rst_resync", resync, 0);
    chk("rst_err",    err,    0);
    chk("rst_cnt",    err_cnt, 0);
`ifdef CNT_MON_STICKY_ERR_EN
    chk("rst_sticky", err_sticky, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, kind;
    bit u, e, clr;
    rst_n = 1'b0; en = 1'b0; din = '0; up_exp = 1'b0;
`ifdef CNT_MON_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    model_reset();
    wrap_seen = 0;
    #12;
    phase = "reset0";
    chk_all_zero();
    @(negedge clk); rst_n = 1'b1;

    phase = "lock_up";
    for (int v = 3; v <= 6; v++) cycle(1, v, 1);
    chk("locked_after_6", locked, 1);

    phase = "wrap";
    wrap_seen = 0;
    for (int v = 12; v <= 17; v++) cycle(1, v & MASK, 1);
    chk("wrap_once", wrap_seen, 1);

    phase = "opp_step";
    cycle(1, 5, 1); cycle(1, 6, 1); cycle(1, 7, 1);
    cycle(1, 6, 1); cycle(1, 5, 1);

    phase = "resync";
    cycle(1, 7, 1); cycle(1, 8, 1); cycle(1, 9, 1); cycle(1, 0, 1);

    phase = "down";
    cycle(1, 15, 0); cycle(1, 14, 0); cycle(0, 3, 1); cycle(1, 13, 0);
    cycle(1, 12, 1); cycle(1, 11, 1); cycle(1, 0, 0); cycle(1, 15, 0);

    phase = "random";
    u = 1;
    for (int i = 0; i < 600; i++) begin
      e   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) u = ~u;
      kind = $urandom_range(0, 9);
      if (kind <= 4)      d = u ? m_prev + 1 : m_prev - 1;
      else if (kind == 5) d = u ? m_prev - 1 : m_prev + 1;
      else if (kind == 6) d = 0;
      else if (kind == 7) d = m_prev;
      else                d = $urandom_range(0, MASK);
      clr = ($urandom_range(0, 15) == 0);
      cycle(e, d & MASK, u, clr);
    end

    phase = "reset_mid_track";
    for (int v = 3; v <= 5; v++) cycle(1, v, 1);
    chk("track_before_rst", locked, 1);
    @(negedge clk); en = 1'b0; #2 rst_n = 1'b0; #1;
    model_reset();
    chk_all_zero();
    @(negedge clk); rst_n = 1'b1;
    cycle(1, 4, 1);
    chk("idle_after_rst", locked, 0);
    cycle(1, 5, 1);

    phase = "saturate";
    cycle(1, 0, 1);
    for (int i = 0; i < 300; i++) begin
      cycle(1, 5, 1, (i % 3) == 0);
      cycle(1, 9, 1, (i % 5) == 0);
    end
    chk("cnt_saturated", err_cnt, CNT_MAX);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
